// File: rtl/hub_message_router_pkg.sv
// Shared constants, message field layout and downstream FSM state for the hub router.
package hub_router_pkg;
  localparam logic [7:0] MSG_GATHER   = 8'h03;
  localparam logic [7:0] ID_BROADCAST = 8'hFF;

  // ID occupies the top byte, TYPE the next byte, PAYLOAD the rest.
  localparam int ID_W   = 8;
  localparam int TYPE_W = 8;
  localparam int HDR_W  = ID_W + TYPE_W;

  typedef enum logic {DS_IDLE, DS_SEND} ds_state_t;

  // MSB index of the TYPE field for a given message width.
  function automatic int type_msb(input int dw);
    return dw - 1 - ID_W;
  endfunction
endpackage

// File: rtl/hub_message_router_if.sv
// Host, downstream and upstream stream bundle of the hub router.
interface hub_message_router_if #(
  parameter int NUM_LEAVES = 4,
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]            host_rx_data;
  logic                             host_rx_valid;
  logic                             host_rx_ready;
  logic [DATA_WIDTH-1:0]            host_tx_data;
  logic                             host_tx_valid;
  logic                             host_tx_ready;
  logic [NUM_LEAVES*DATA_WIDTH-1:0] down_tx_data;
  logic [NUM_LEAVES-1:0]            down_tx_valid;
  logic [NUM_LEAVES-1:0]            down_tx_ready;
  logic [NUM_LEAVES*DATA_WIDTH-1:0] up_rx_data;
  logic [NUM_LEAVES-1:0]            up_rx_valid;
  logic [NUM_LEAVES-1:0]            up_rx_ready;
  logic                             bad_dest;

  // Router side.
  modport master (
    input  host_rx_data, host_rx_valid, host_tx_ready, down_tx_ready, up_rx_data, up_rx_valid,
    output host_rx_ready, host_tx_data, host_tx_valid, down_tx_data, down_tx_valid, up_rx_ready,
           bad_dest
  );

  // Host and leaf side.
  modport slave (
    output host_rx_data, host_rx_valid, host_tx_ready, down_tx_ready, up_rx_data, up_rx_valid,
    input  host_rx_ready, host_tx_data, host_tx_valid, down_tx_data, down_tx_valid, up_rx_ready,
           bad_dest
  );
endinterface

// File: rtl/hub_message_router_fifo.sv
// Per-leaf synchronous FIFO; full/empty derive from a registered occupancy count.
module hub_leaf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
endmodule

// File: rtl/hub_message_router.sv
// Root-hub router: downstream unicast/broadcast FSM, upstream per-leaf FIFOs,
// round-robin merge and a gather barrier that folds one report per leaf into one.
module hub_message_router
  import hub_router_pkg::*;
#(
  parameter int NUM_LEAVES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  hub_message_router_if.master bus
);
  localparam int NL   = NUM_LEAVES;
  localparam int DW   = DATA_WIDTH;
  localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
  localparam int PL_W = DW - HDR_W;
  localparam int TMSB = type_msb(DW);

  // First requester at or after (last+1) mod NL; returns {hit, index}.
  function automatic logic [LW:0] rr_pick(input logic [NL-1:0] req, input logic [LW-1:0] last);
    logic [NL-1:0] rot;
    logic          hit;
    logic [LW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    rot = NL'({req, req} >> (int'(last) + 1));
    for (int i = 0; i < NL; i++) begin
      if (!hit && rot[i]) begin
        hit = 1'b1;
        idx = LW'((int'(last) + 1 + i) % NL);
      end
    end
    return {hit, idx};
  endfunction

  logic run;

  // Ready outputs stay low while in reset and rise the cycle after release.
  always_ff @(posedge clk) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  // ---------------- downstream ----------------
  ds_state_t     state;
  logic [NL-1:0] pend;
  logic [DW-1:0] cmd;
  logic          rx_rdy, bad;
  logic [7:0]    rx_id;
  logic [NL-1:0] uni_mask;
  logic          uni_ok;

  assign rx_id = bus.host_rx_data[DW-1 -: ID_W];

  // Unicast destination decode: leaf k answers to ID k+1.
  always_comb begin
    uni_mask = '0;
    uni_ok   = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (rx_id == 8'(k + 1)) begin
        uni_mask[k] = 1'b1;
        uni_ok      = 1'b1;
      end
    end
  end

  // Command FSM: latch, fan out, retire each leaf on its own handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DS_IDLE;
      pend   <= '0;
      cmd    <= '0;
      rx_rdy <= 1'b0;
      bad    <= 1'b0;
    end else begin
      case (state)
        DS_IDLE: begin
          rx_rdy <= 1'b1;
          if (bus.host_rx_valid && rx_rdy) begin
            cmd <= bus.host_rx_data;
            if (rx_id == ID_BROADCAST) begin
              pend   <= '1;
              state  <= DS_SEND;
              rx_rdy <= 1'b0;
            end else if (uni_ok) begin
              pend   <= uni_mask;
              state  <= DS_SEND;
              rx_rdy <= 1'b0;
            end else begin
              bad <= 1'b1;
            end
          end
        end
        DS_SEND: begin
          pend <= pend & ~bus.down_tx_ready;
          if ((pend & ~bus.down_tx_ready) == '0) begin
            state  <= DS_IDLE;
            rx_rdy <= 1'b1;
          end
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

  assign bus.host_rx_ready = rx_rdy;
  assign bus.down_tx_valid = pend;
  assign bus.down_tx_data  = {NL{cmd}};
  assign bus.bad_dest      = bad;

  // ---------------- upstream ----------------
  logic [NL-1:0][DW-1:0] head;
  logic [NL-1:0]         full, empty, wr, rd, is_g;

  assign bus.up_rx_ready = {NL{run}} & ~full;
  assign wr              = bus.up_rx_valid & bus.up_rx_ready;

  for (genvar k = 0; k < NL; k++) begin : g_leaf
    logic [DW-1:0] wdata;
    // Stamp the source ID so the host can tell leaves apart.
    assign wdata = {8'(k + 1), bus.up_rx_data[k*DW +: DW-ID_W]};
    hub_leaf_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr[k]),
      .wr_data (wdata),
      .rd_en   (rd[k]),
      .rd_data (head[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );
  end

  logic [LW-1:0]   a_last, g_last, a_idx, g_idx;
  logic            a_hit, g_hit, can_load, release_g, grant;
  logic [NL-1:0]   gmask, gmask_nx, g_pop_oh, a_oh;
  logic [PL_W-1:0] gacc, gacc_nx;
  logic [DW-1:0]   out_data;
  logic            out_vld;

  // Head classification, arbitration and gather-barrier next state.
  always_comb begin
    for (int k = 0; k < NL; k++) is_g[k] = (head[k][TMSB -: TYPE_W] == MSG_GATHER);
    {a_hit, a_idx} = rr_pick(~empty & ~is_g, a_last);
    {g_hit, g_idx} = rr_pick(~empty & is_g & ~gmask, g_last);
    g_pop_oh = '0;
    if (g_hit) g_pop_oh[g_idx] = 1'b1;
    gmask_nx  = gmask | g_pop_oh;
    gacc_nx   = g_hit ? (gacc | head[g_idx][PL_W-1:0]) : gacc;
    can_load  = !out_vld || bus.host_tx_ready;
    // A completed barrier outranks every leaf for the output register.
    release_g = (&gmask_nx) && can_load;
    grant     = a_hit && can_load && !(&gmask_nx);
    a_oh = '0;
    if (grant) a_oh[a_idx] = 1'b1;
    rd = g_pop_oh | a_oh;
  end

  // Output register, barrier state and round-robin pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      gmask    <= '0;
      gacc     <= '0;
      a_last   <= LW'(NL - 1);
      g_last   <= LW'(NL - 1);
    end else begin
      if (g_hit) g_last <= g_idx;
      if (release_g) begin
        out_data <= {8'h00, MSG_GATHER, gacc_nx};
        out_vld  <= 1'b1;
        gmask    <= '0;
        gacc     <= '0;
      end else begin
        gmask <= gmask_nx;
        gacc  <= gacc_nx;
        if (grant) begin
          out_data <= head[a_idx];
          out_vld  <= 1'b1;
          a_last   <= a_idx;
        end else if (bus.host_tx_ready) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign bus.host_tx_data  = out_data;
  assign bus.host_tx_valid = out_vld;
endmodule

// File: tb/tb_hub_message_router.sv
// Directed bench for hub_message_router: downstream checks inline, upstream via scoreboard.
module tb_hub_message_router;
  localparam int NL = 4;
  localparam int DW = 64;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hub_message_router_if #(.NUM_LEAVES(NL), .DATA_WIDTH(DW)) bus();

  hub_message_router #(.NUM_LEAVES(NL), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int got = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] lq[NL][$];
  int ldly[NL];
  int hs_cnt[NL];
  int hs_base[NL];
  int bdly[NL] = '{1, 3, 5, 2};

  function automatic logic [DW-1:0] msg(input logic [7:0] id, input logic [7:0] ty,
                                        input logic [47:0] pl);
    return {id, ty, pl};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every host-side handshake pops and checks one expected message.
  initial forever begin
    @(negedge clk);
    if (!reset && bus.host_tx_valid && bus.host_tx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %h want none", bus.host_tx_data);
      end else begin
        got++;
        chk("host_tx", bus.host_tx_data, sb.pop_front());
      end
    end
  end

  // Downstream handshake counter per leaf.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NL; k++)
      if (bus.down_tx_valid[k] && bus.down_tx_ready[k]) hs_cnt[k]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Drive leaf queues (each starting after ldly cycles) until they and the scoreboard drain.
  task automatic run_up(input int maxc, input bit gapchk, input int total);
    int c = 0;
    bit busy = 1'b1;
    logic [NL-1:0] fire;
    while (busy && c < maxc) begin
      for (int k = 0; k < NL; k++) begin
        bus.up_rx_valid[k] = (c >= ldly[k]) && (lq[k].size() > 0);
        bus.up_rx_data[k*DW +: DW] = (lq[k].size() > 0) ? lq[k][0] : '0;
      end
      fire = bus.up_rx_valid & bus.up_rx_ready;
      tick();
      for (int k = 0; k < NL; k++) if (fire[k]) void'(lq[k].pop_front());
      if (gapchk && got > 0 && got < total) chk("no_gap", bus.host_tx_valid, 1'b1);
      c++;
      busy = (sb.size() > 0);
      for (int k = 0; k < NL; k++) if (lq[k].size() > 0) busy = 1'b1;
    end
    bus.up_rx_valid = '0;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL run_up_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    int wcnt;
    logic fire0;
    bus.host_rx_data  = '0;
    bus.host_rx_valid = 1'b0;
    bus.host_tx_ready = 1'b0;
    bus.down_tx_ready = '0;
    bus.up_rx_data    = '0;
    bus.up_rx_valid   = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_rx_ready",   bus.host_rx_ready, 1'b0);
    chk("rst_up_ready",   bus.up_rx_ready, 4'h0);
    chk("rst_tx_valid",   bus.host_tx_valid, 1'b0);
    chk("rst_down_valid", bus.down_tx_valid, 4'h0);
    chk("rst_bad",        bus.bad_dest, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rx_ready", bus.host_rx_ready, 1'b1);
    chk("post_up_ready", bus.up_rx_ready, 4'hF);

    // Unicast to ID 3 (leaf 2)
    bus.host_rx_data  = msg(8'd3, 8'h01, 48'h1234);
    bus.host_rx_valid = 1'b1;
    tick();
    bus.host_rx_valid = 1'b0;
    chk("uni_valid", bus.down_tx_valid, 4'b0100);
    chk("uni_data",  bus.down_tx_data[2*DW +: DW], msg(8'd3, 8'h01, 48'h1234));
    chk("uni_busy",  bus.host_rx_ready, 1'b0);
    tick();
    chk("uni_hold", bus.down_tx_valid, 4'b0100);
    bus.down_tx_ready = 4'b0100;
    tick();
    bus.down_tx_ready = '0;
    chk("uni_done",     bus.down_tx_valid, 4'h0);
    chk("uni_rx_ready", bus.host_rx_ready, 1'b1);

    // Broadcast with staggered leaf readiness
    for (int k = 0; k < NL; k++) hs_base[k] = hs_cnt[k];
    bus.host_rx_data  = msg(8'hFF, 8'h02, 48'hABCD);
    bus.host_rx_valid = 1'b1;
    tick();
    bus.host_rx_valid = 1'b0;
    chk("bc_valid", bus.down_tx_valid, 4'hF);
    chk("bc_data0", bus.down_tx_data[0 +: DW], msg(8'hFF, 8'h02, 48'hABCD));
    for (int t = 1; t <= 5; t++) begin
      for (int k = 0; k < NL; k++) bus.down_tx_ready[k] = (t >= bdly[k]);
      tick();
      if (t == 3) chk("bc_partial", bus.down_tx_valid, 4'b0100);
      if (t == 4) chk("bc_busy", bus.host_rx_ready, 1'b0);
    end
    chk("bc_done",     bus.down_tx_valid, 4'h0);
    chk("bc_rx_ready", bus.host_rx_ready, 1'b1);
    tick();
    bus.down_tx_ready = '0;
    for (int k = 0; k < NL; k++) chk($sformatf("bc_hs%0d", k), hs_cnt[k] - hs_base[k], 1);

    // Invalid destinations: ID 0 and ID 5
    bus.host_rx_data  = msg(8'd0, 8'h01, 48'h55);
    bus.host_rx_valid = 1'b1;
    tick();
    bus.host_rx_valid = 1'b0;
    chk("bad0_valid",    bus.down_tx_valid, 4'h0);
    chk("bad0_flag",     bus.bad_dest, 1'b1);
    chk("bad0_rx_ready", bus.host_rx_ready, 1'b1);
    bus.host_rx_data  = msg(8'd5, 8'h01, 48'h66);
    bus.host_rx_valid = 1'b1;
    tick();
    bus.host_rx_valid = 1'b0;
    tick();
    chk("bad5_valid", bus.down_tx_valid, 4'h0);
    chk("bad5_flag",  bus.bad_dest, 1'b1);

    // Round robin: four leaves stream six messages each, garbage source ID overwritten
    got = 0;
    bus.host_tx_ready = 1'b1;
    for (int k = 0; k < NL; k++) ldly[k] = 0;
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < NL; k++) begin
        lq[k].push_back(msg(8'h77, 8'h01, 48'(k * 256 + s)));
        sb.push_back(msg(8'(k + 1), 8'h01, 48'(k * 256 + s)));
      end
    run_up(80, 1'b1, 24);
    chk("rr_count", got, 24);

    // Gather: leaf 0 sends a second gather before the barrier releases
    lq[0].push_back(msg(8'h00, 8'h03, 48'h1));
    lq[0].push_back(msg(8'h00, 8'h03, 48'h10));
    lq[1].push_back(msg(8'h00, 8'h03, 48'h2));
    lq[2].push_back(msg(8'h00, 8'h03, 48'h4));
    lq[3].push_back(msg(8'h00, 8'h03, 48'h8));
    ldly = '{0, 2, 3, 4};
    sb.push_back(msg(8'h00, 8'h03, 48'hF));
    run_up(60, 1'b0, 0);
    repeat (4) tick();
    // Second round completes with leaf 0's held report
    lq[1].push_back(msg(8'h00, 8'h03, 48'h20));
    lq[2].push_back(msg(8'h00, 8'h03, 48'h40));
    lq[3].push_back(msg(8'h00, 8'h03, 48'h80));
    ldly = '{0, 0, 0, 0};
    sb.push_back(msg(8'h00, 8'h03, 48'hF0));
    run_up(60, 1'b0, 0);
    repeat (4) tick();
    chk("gather_drained", sb.size(), 0);

    // Backpressure: output register occupied, leaf 0 fills its FIFO
    bus.host_tx_ready = 1'b0;
    chk("bad_sticky", bus.bad_dest, 1'b1);
    bus.up_rx_data[3*DW +: DW] = msg(8'h77, 8'h01, 48'hBEEF);
    bus.up_rx_valid = 4'b1000;
    tick();
    bus.up_rx_valid = '0;
    tick();
    chk("bp_valid", bus.host_tx_valid, 1'b1);
    chk("bp_data",  bus.host_tx_data, msg(8'd4, 8'h01, 48'hBEEF));
    wcnt = 0;
    bus.up_rx_data[0 +: DW] = msg(8'h77, 8'h01, 48'h100);
    bus.up_rx_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      fire0 = bus.up_rx_ready[0];
      tick();
      if (fire0) wcnt++;
    end
    bus.up_rx_valid = '0;
    chk("bp_writes",     wcnt, 4);
    chk("bp_ready_drop", bus.up_rx_ready[0], 1'b0);
    chk("bp_hold_valid", bus.host_tx_valid, 1'b1);
    chk("bp_hold_data",  bus.host_tx_data, msg(8'd4, 8'h01, 48'hBEEF));

    // Reset while stalled upstream and mid-broadcast
    bus.host_rx_data  = msg(8'hFF, 8'h01, 48'h7);
    bus.host_rx_valid = 1'b1;
    tick();
    bus.host_rx_valid = 1'b0;
    chk("rst2_pre_down", bus.down_tx_valid, 4'hF);
    reset = 1'b1;
    tick();
    chk("rst2_tx_valid",   bus.host_tx_valid, 1'b0);
    chk("rst2_down_valid", bus.down_tx_valid, 4'h0);
    chk("rst2_up_ready",   bus.up_rx_ready, 4'h0);
    chk("rst2_rx_ready",   bus.host_rx_ready, 1'b0);
    chk("rst2_bad",        bus.bad_dest, 1'b0);
    reset = 1'b0;
    bus.host_tx_ready = 1'b1;
    repeat (10) tick();
    chk("rst2_tx_idle",   bus.host_tx_valid, 1'b0);
    chk("rst2_down_idle", bus.down_tx_valid, 4'h0);
    chk("rst2_up_back",   bus.up_rx_ready, 4'hF);
    chk("sb_empty",       sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub_message_router.md
# hub_message_router

Parametrised root-hub message router for the multi-FPGA decoder tree. It sits between one host/control channel and `NUM_LEAVES` leaf decoder links, using 64-bit-class valid/ready streams. Downstream it delivers unicast or broadcast commands. Upstream it merges leaf traffic into one stream through per-leaf FIFOs, a round-robin arbiter and a gather barrier that collapses one report per leaf into a single combined message.

## Interface
- `NUM_LEAVES`, default 4: number of leaf links, range 1..254. Leaf k carries FPGA_ID k+1.
- `DATA_WIDTH`, default 64: message width, minimum 24.
- `FIFO_DEPTH`, default 4: per-leaf upstream FIFO depth, power of two, at least 2.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `host_rx_data` in DATA_WIDTH: command from the host.
- `host_rx_valid` in 1, `host_rx_ready` out 1: command handshake.
- `host_tx_data` out DATA_WIDTH: message to the host.
- `host_tx_valid` out 1, `host_tx_ready` in 1: message handshake.
- `down_tx_data` out NUM_LEAVES*DATA_WIDTH: per-leaf command slices. Slice k is `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `down_tx_valid` out NUM_LEAVES, `down_tx_ready` in NUM_LEAVES.
- `up_rx_data` in NUM_LEAVES*DATA_WIDTH: per-leaf messages.
- `up_rx_valid` in NUM_LEAVES, `up_rx_ready` out NUM_LEAVES.
- `bad_dest` out 1: sticky flag, set when a command has an invalid destination. Cleared only by reset.

## Operation
- Message fields:
  - ID at `[DW-1 -: 8]`.
  - TYPE at `[DW-9 -: 8]`.
  - PAYLOAD in the remaining bits.
- Downstream FSM has two states, IDLE and SEND.
  - IDLE: `host_rx_ready`=1. On handshake, latch the command and decode ID.
  - ID=8'hFF: broadcast. Set pending mask = all ones, go to SEND.
  - ID in 1..NUM_LEAVES: unicast. Set pending mask = one-hot bit ID-1, go to SEND.
  - Any other ID: drop the command, set `bad_dest`, stay in IDLE.
  - SEND: `host_rx_ready`=0. `down_tx_valid` equals the pending mask, and all slices carry the latched command.
  - Each leaf's bit clears independently on its own handshake. Leaves may accept in different cycles.
  - When the mask reaches zero, return to IDLE.
- Upstream path:
  - Leaf k writes its FIFO k when `up_rx_valid[k] && up_rx_ready[k]`. `up_rx_ready[k]` = FIFO not full.
  - The ID field is overwritten with k+1 on write.
- Gather barrier:
  - A FIFO head whose TYPE = `MSG_GATHER` is never forwarded.
  - When leaf k's gather bit is clear, the head is popped, bit k is set, and its PAYLOAD is ORed into an accumulator.
  - When leaf k's gather bit is already set, that FIFO stalls until the barrier is released.
  - When the gather mask is all ones, a combined message is emitted: ID=0, TYPE=`MSG_GATHER`, PAYLOAD=accumulator.
  - The mask and accumulator clear on the cycle the combined message is loaded into the output register.
- Arbiter:
  - Round-robin over FIFO heads that are non-empty and not gather.
  - Priority starts at leaf (last grant + 1) mod NUM_LEAVES. The last-grant pointer resets to NUM_LEAVES-1, so leaf 0 has first priority.
  - A pending combined gather message has priority over all leaves.
  - A grant happens only when the output register is empty or being drained that cycle.
- Only one gather pop is performed per cycle. Among gather-head FIFOs, round-robin order is used.

## Timing
- Reset values: all `valid` outputs 0, `host_rx_ready` 0, `up_rx_ready` 0 and `bad_dest` 0, all while `reset` is high. FSM goes to IDLE, FIFOs, masks and accumulator are cleared.
- Cycle after reset deasserts: `host_rx_ready`=1 and `up_rx_ready`=all ones.
- Reset asserted mid-SEND or mid-gather: everything in flight is discarded and nothing is emitted afterwards.
- Downstream latency: host handshake at cycle N gives `down_tx_valid` at N+1. The next command can be accepted one cycle after the last leaf handshake.
- Upstream latency: leaf write at N gives `host_tx_valid` at N+2 when uncontended. Sustained throughput is one message per cycle.
- Gather latency: the last gather pop at N gives the combined message valid at N+1.
- `host_tx_data` is held stable while valid and not ready.
- A FIFO that is full and popped in the same cycle still reports ready=0 that cycle, because ready comes from the registered count.

## Structure
- Package `hub_router_pkg` holds:
  - `MSG_GATHER = 8'h03`.
  - `ID_BROADCAST = 8'hFF`.
  - Field offset/width localparams.
  - The downstream state enum.
- Sub-module `hub_leaf_fifo`: synchronous FIFO, parametrised by width and depth, with a registered count and full/empty flags. It is instantiated once per leaf.
- The arbiter, gather barrier and downstream FSM live in the top module.

## Test plan
- Unicast: host sends ID=3, payload 0x1234. Only `down_tx_valid[2]` rises, at N+1. `host_rx_ready` returns to 1 the cycle after leaf 2 accepts.
- Broadcast with staggered readies: ID=FF, with leaves becoming ready at +1, +3, +5, +2 cycles. Each leaf sees exactly one handshake, and the FSM returns to IDLE after the last one.
- Invalid destination: host sends ID=0, then ID=5 with NUM_LEAVES=4. No `down_tx_valid` is asserted and `bad_dest`=1 stays set.
- Round robin: all 4 leaves stream continuously with `host_tx_ready`=1. The host receives source IDs in the order 1,2,3,4,1,2,…, with no gaps.
- Gather:
  - Leaves send gather payloads 0x1, 0x2, 0x4, 0x8, with leaf 0 sending a second gather early.
  - Exactly one message is emitted: ID=0, TYPE=03, payload 0xF. Leaf 0's second gather is held until after the release.
- Backpressure plus reset:
  - `host_tx_ready`=0 with FIFO_DEPTH=4: `up_rx_ready[k]` drops after 4 writes and `host_tx_data` stays stable.
  - Reset mid-stream: all valids are 0 on the next cycle.
